// File: rtl/alt_vipitc131_common_control_packet_decoder_pkg.sv
// alt_vipitc131_common_control_packet_decoder_pkg: packet type codes, control symbol count and decoder FSM states
package alt_vipitc131_common_control_packet_decoder_pkg;
  localparam logic [3:0] PKT_VIDEO = 4'h0;
  localparam logic [3:0] PKT_CTRL = 4'hF;
  localparam int CTRL_SYMBOLS = 9;
  typedef enum logic [2:0] {ST_IDLE, ST_CTRL, ST_VIDEO, ST_DISCARD, ST_USER} state_t;
endpackage

// File: rtl/alt_vipitc131_ctrl_symbol_capture.sv
// alt_vipitc131_ctrl_symbol_capture: stores the 9 control nibbles of a control packet
// Ports: clk, rst_n (async active-low); wr (accepted control data beat);
// beat_cnt (data beats already taken); nibs (low nibble of every lane of the beat);
// shadow (nibbles including the current beat, symbol 0 in bits [3:0]);
// complete (all 9 symbols present once the current beat is counted).
module alt_vipitc131_ctrl_symbol_capture
  import alt_vipitc131_common_control_packet_decoder_pkg::*;
#(
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr,
  input  logic [3:0]                          beat_cnt,
  input  logic [SYMBOLS_PER_BEAT-1:0][3:0]    nibs,
  output logic [CTRL_SYMBOLS-1:0][3:0]        shadow,
  output logic                                complete
);
  logic [CTRL_SYMBOLS-1:0][3:0] shadow_q, shadow_d;
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < CTRL_SYMBOLS; k++)
      if (wr && beat_cnt == 4'(k / SYMBOLS_PER_BEAT)) shadow_d[k] = nibs[k % SYMBOLS_PER_BEAT];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shadow_q <= '0;
    else shadow_q <= shadow_d;
  // the eop beat's own symbols must count, so expose the merged value and completeness
  assign shadow = shadow_d;
  assign complete = ({4'd0, beat_cnt} + 8'd1) * 8'(SYMBOLS_PER_BEAT) >= 8'(CTRL_SYMBOLS);
endmodule

// File: rtl/alt_vipitc131_common_control_packet_decoder.sv
// alt_vipitc131_common_control_packet_decoder: VIP stream decoder, extracts control fields and forwards video payload
// Ports: clk, rst_n (async active-low); din_* Avalon-ST sink; dout_* video payload source
// (zero latency, combinational from din); ctrl_width/height/interlaced hold the last complete
// control packet; ctrl_valid pulses on update; ctrl_error pulses the cycle after a framing error.
// Build option VIP_CPD_USER_PASS_EN: forward user packets whole (header included) and add dout_user.
module alt_vipitc131_common_control_packet_decoder
  import alt_vipitc131_common_control_packet_decoder_pkg::*;
#(
  parameter int BITS_PER_SYMBOL = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  output logic                                       din_ready,
  input  logic                                       din_valid,
  input  logic                                       din_sop,
  input  logic                                       din_eop,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  input  logic                                       dout_ready,
  output logic                                       dout_valid,
  output logic                                       dout_sop,
  output logic                                       dout_eop,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic [15:0]                                ctrl_width,
  output logic [15:0]                                ctrl_height,
  output logic [3:0]                                 ctrl_interlaced,
  output logic                                       ctrl_valid,
  output logic                                       ctrl_error
`ifdef VIP_CPD_USER_PASS_EN
  , output logic                                     dout_user
`endif
);
  state_t state_q, state_d, hdr_state, user_state;
  logic [3:0] cnt_q, cnt_d, interlaced_q, interlaced_d, pkt_type;
  logic [15:0] width_q, width_d, height_q, height_d;
  logic first_q, first_d, valid_q, valid_d, error_q, error_d;
  logic acc, in_fwd, hdr_user, wr, complete;
  logic [SYMBOLS_PER_BEAT-1:0][3:0] nibs;
  logic [CTRL_SYMBOLS-1:0][3:0] shadow;
  assign pkt_type = din_data[3:0];
`ifdef VIP_CPD_USER_PASS_EN
  // a user header is forwarded in the same cycle it is decoded
  assign hdr_user = din_sop && pkt_type != PKT_VIDEO && pkt_type != PKT_CTRL;
  assign user_state = ST_USER;
  assign dout_user = hdr_user || state_q == ST_USER;
`else
  assign hdr_user = 1'b0;
  assign user_state = ST_DISCARD;
`endif
  assign in_fwd = state_q == ST_VIDEO || state_q == ST_USER;
  assign din_ready = in_fwd || hdr_user ? dout_ready : 1'b1;
  assign acc = din_valid && din_ready;
  // a sop beat inside a forwarded packet is the next header, never payload
  assign dout_valid = din_valid && (in_fwd && !din_sop || hdr_user);
  assign dout_sop = hdr_user || state_q == ST_VIDEO && first_q;
  assign dout_eop = din_eop;
  assign dout_data = din_data;
  assign hdr_state = din_eop ? ST_IDLE : pkt_type == PKT_VIDEO ? ST_VIDEO :
                     pkt_type == PKT_CTRL ? ST_CTRL : user_state;
  assign wr = acc && state_q == ST_CTRL && !din_sop;
  always_comb begin
    for (int l = 0; l < SYMBOLS_PER_BEAT; l++) nibs[l] = din_data[l*BITS_PER_SYMBOL +: 4];
  end
  alt_vipitc131_ctrl_symbol_capture #(.SYMBOLS_PER_BEAT(SYMBOLS_PER_BEAT)) u_capture (
    .clk(clk), .rst_n(rst_n), .wr(wr), .beat_cnt(cnt_q), .nibs(nibs),
    .shadow(shadow), .complete(complete)
  );
  always_comb begin
    state_d = !acc ? state_q : din_sop ? hdr_state : din_eop ? ST_IDLE : state_q;
    cnt_d = acc && din_sop ? 4'd0 : wr && cnt_q != 4'hF ? cnt_q + 4'd1 : cnt_q;
    first_d = acc ? din_sop : first_q;
    valid_d = wr && din_eop && complete;
    error_d = acc && (din_sop ? state_q != ST_IDLE : state_q == ST_IDLE || wr && din_eop && !complete);
    width_d = valid_d ? {shadow[0], shadow[1], shadow[2], shadow[3]} : width_q;
    height_d = valid_d ? {shadow[4], shadow[5], shadow[6], shadow[7]} : height_q;
    interlaced_d = valid_d ? shadow[8] : interlaced_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      first_q <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      width_q <= '0;
      height_q <= '0;
      interlaced_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      first_q <= first_d;
      valid_q <= valid_d;
      error_q <= error_d;
      width_q <= width_d;
      height_q <= height_d;
      interlaced_q <= interlaced_d;
    end
  assign ctrl_width = width_q;
  assign ctrl_height = height_q;
  assign ctrl_interlaced = interlaced_q;
  assign ctrl_valid = valid_q;
  assign ctrl_error = error_q;
endmodule
